regfile_wb_arbiter: RTL and testbench

Round-robin write-back arbiter sharing the single 16-bit write port of the processor register file between several requesters (ALU, memory load, immediate/link path). Each requester presents a valid/address/data bundle. The arbiter grants at most one per cycle and drives a registered write-enable/address/data bundle into the register file one cycle later. It sits between the execute/memory stages and the register file and owns write-port sequencing and fairness.

---
 rtl/regarb_pkg.sv | 16 +
 rtl/rr_picker.sv | 21 ++
 rtl/regfile_wb_arbiter.sv | 60 ++++++
 tb/tb_regfile_wb_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/regarb_pkg.sv
// regarb_pkg: shared defaults, zero-register constant and reference round-robin pick function.
package regarb_pkg;
  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int ZERO_REG = 0;
  localparam int MAX_REQ = 8;
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid, input logic [2:0] ptr, input int n);
    int i;
    rr_pick = '0;
    for (int k = n - 1; k >= 0; k--) begin
      i = (int'(ptr) + k) % n;
      if (valid[i]) rr_pick = MAX_REQ'(1) << i;
    end
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: rotate / lowest-set-bit / rotate-back round-robin one-hot grant with hold suppression.
module rr_picker #(
  parameter int N = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  input  logic          hold,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner
);
  logic [N-1:0] rot, first;
  assign rot = N'({valid, valid} >> ptr);
  assign first = rot & (~rot + N'(1));
  assign grant = hold ? '0 : N'(({first, first} << ptr) >> N);
  always_comb begin
    winner = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) winner = PW'(i);
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter for the register-file write port with registered write bundle.
// Optional burst lock enabled by defining REGARB_LOCK_EN.
module regfile_wb_arbiter import regarb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ZERO_RO = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic                      hold,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_data
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0] ptr, winner, ptr_next;
  logic any, keep;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .hold  (hold),
    .grant (grant),
    .winner(winner)
  );
  assign any = |grant;
  assign sel_addr = req_addr[winner*ADDR_W +: ADDR_W];
  assign sel_data = req_data[winner*DATA_W +: DATA_W];
`ifdef REGARB_LOCK_EN
  // hold forces grant to zero, so the lock can never act while stalled
  assign keep = req_lock[winner];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign keep = 1'b0;
`endif
  assign ptr_next = keep ? winner : (winner == PW'(NUM_REQ - 1) ? '0 : winner + PW'(1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      rf_we <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      rf_we <= any && !(ZERO_RO != 0 && sel_addr == ADDR_W'(ZERO_REG));
      if (any) begin
        ptr <= ptr_next;
        rf_addr <= sel_addr;
        rf_data <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks against a behavioural arbitration model.
module tb_regfile_wb_arbiter;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_lock = '0, grant;
  logic [N*3-1:0] req_addr = '0;
  logic [N*16-1:0] req_data = '0;
  logic hold = 1'b0;
  logic rf_we;
  logic [2:0] rf_addr;
  logic [15:0] rf_data;
  int tests = 0, fails = 0;
  int m_ptr = 0;
  logic m_we = 1'b0;
  logic [2:0] m_addr = '0;
  logic [15:0] m_data = '0;
  logic [N-1:0] eg, g_obs;
  logic [2:0] rot_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_lock(req_lock), .hold(hold), .grant(grant), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] a, input logic [15:0] d);
    req_valid[i] = v;
    req_addr[i*3 +: 3] = a;
    req_data[i*16 +: 16] = d;
  endtask

  // first valid requester scanning upward from the pointer, wrapping around
  function automatic logic [N-1:0] model_grant();
    int i;
    if (hold) return '0;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (req_valid[i]) return N'(1) << i;
    end
    return '0;
  endfunction

  task automatic model_clear();
    m_ptr = 0;
    m_we = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic cycle();
    int w;
    @(negedge clk);
    eg = model_grant();
    g_obs = grant;
    chk("grant", grant, eg);
    @(posedge clk);
    if (eg != 0) begin
      w = $clog2(eg);
      m_addr = req_addr[w*3 +: 3];
      m_data = req_data[w*16 +: 16];
      m_we = (m_addr != 0);
`ifdef REGARB_LOCK_EN
      m_ptr = req_lock[w] ? w : (w + 1) % N;
`else
      m_ptr = (w + 1) % N;
`endif
    end else m_we = 1'b0;
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_addr", rf_addr, m_addr);
    chk("rf_data", rf_data, m_data);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    set_req(0, 1, 3'd3, 16'h1234);
    set_req(1, 1, 3'd4, 16'h2222);
    set_req(2, 1, 3'd6, 16'h3333);
    #12;
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_data", rf_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    chk("rel_grant", g_obs, 3'b001);
    chk("rel_addr", rf_addr, 3);
    chk("rel_data", rf_data, 16'h1234);

    req_valid = '0;
    set_req(1, 1, 3'd5, 16'h8001);
    cycle();
    chk("single_grant", g_obs, 3'b010);
    chk("single_we", rf_we, 1);
    chk("single_addr", rf_addr, 5);
    chk("single_data", rf_data, 16'h8001);

    req_valid = '1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_we", rf_we, 0);
    chk("async_addr", rf_addr, 0);
    chk("async_data", rf_data, 0);
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;

    set_req(0, 1, 3'd1, 16'hA000);
    set_req(1, 1, 3'd2, 16'hB000);
    set_req(2, 1, 3'd3, 16'hC000);
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("rot_grant", g_obs, rot_seq[c]);
      chk("rot_we", rf_we, 1);
    end

    req_valid = '0;
    set_req(2, 1, 3'd0, 16'hFFFF);
    cycle();
    chk("zero_grant", g_obs, 3'b100);
    chk("zero_we", rf_we, 0);

    req_valid = '0;
    set_req(0, 1, 3'd7, 16'h0F0F);
    hold = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("hold_grant", g_obs, 0);
      chk("hold_we", rf_we, 0);
      chk("hold_ptr", dut.ptr, m_ptr);
    end
    hold = 1'b0;
    cycle();
    chk("unhold_grant", g_obs, 3'b001);

`ifdef REGARB_LOCK_EN
    do_reset();
    req_valid = '0;
    set_req(0, 1, 3'd1, 16'h0001);
    set_req(1, 1, 3'd2, 16'h0002);
    req_lock = 3'b001;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("lock_grant", g_obs, 3'b001);
    end
    req_lock = '0;
    cycle();
    chk("unlock_grant0", g_obs, 3'b001);
    cycle();
    chk("unlock_grant1", g_obs, 3'b010);
`endif

    req_valid = '0;
    req_lock = '0;
    eg = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || eg[i]) begin
          set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
`ifdef REGARB_LOCK_EN
          req_lock[i] = ($urandom_range(0, 3) == 0);
`endif
        end
      hold = ($urandom_range(0, 4) == 0);
      if (c == 200) do_reset();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
